// File: rtl/ac_motor_ramp_control.sv
// ac_motor_ramp_control: slew-limited power ramp with start/stop FSM driving V/f modulator words
module ac_motor_ramp_control #(
    parameter int RES_BITS   = 12,
    parameter int DELAY_BITS = 11,
    parameter int DELAY_MIN  = 1000,
    parameter int RATE_BITS  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENABLE,
    input  logic [RES_BITS-1:0]   POWER,
    input  logic [15:0]           MOD_DELAY_UMIN,
    input  logic [RATE_BITS-1:0]  RAMP_RATE,
    output logic                  MODULATION,
    output logic [DELAY_BITS-1:0] DELAY,
    output logic [RES_BITS-1:0]   FREQUENCY,
    output logic [RES_BITS-1:0]   AMPLITUDE,
    output logic [1:0]            STATE,
    output logic                  AT_TARGET
);
    typedef enum logic [1:0] {IDLE, RAMP, RUN, STOP} state_t;
    state_t state, state_nx;
    logic [RES_BITS-1:0] target, p, p_nx, u_min_ext;
    logic [6:0] u_min, delay_add;
    logic mod_req, en, tick;
    logic [RATE_BITS-1:0] presc, presc_nx, rate_l, rate_cur;
    logic [DELAY_BITS:0] delay_sum;
    // rate is sampled only when a prescaler period starts, so a new RAMP_RATE lands at the next wrap
    assign rate_cur = (presc == '0) ? ((RAMP_RATE == '0) ? RATE_BITS'(1) : RAMP_RATE) : rate_l;
    assign tick = (state == RAMP || state == STOP) && presc == rate_cur - RATE_BITS'(1);
    assign u_min_ext = RES_BITS'(u_min);
    assign delay_sum = (DELAY_BITS+1)'(DELAY_MIN) + (DELAY_BITS+1)'(delay_add);
    // register the raw host inputs; everything downstream uses these copies
    always_ff @(posedge CLK) begin
        if (RST) begin
            target    <= '0;
            u_min     <= '0;
            delay_add <= '0;
            mod_req   <= 1'b1;
            en        <= 1'b0;
        end else begin
            target    <= POWER;
            u_min     <= MOD_DELAY_UMIN[7:1];
            delay_add <= MOD_DELAY_UMIN[14:8];
            mod_req   <= MOD_DELAY_UMIN[15];
            en        <= ENABLE;
        end
    end
    // next state, next ramped power and prescaler; stop request beats reaching the target
    always_comb begin
        state_nx = state;
        p_nx     = p;
        case (state)
            IDLE: begin
                p_nx     = '0;
                state_nx = en ? RAMP : IDLE;
            end
            RAMP: begin
                p_nx     = !tick ? p : (p < target) ? p + RES_BITS'(1) : (p > target) ? p - RES_BITS'(1) : p;
                state_nx = !en ? STOP : (p_nx == target) ? RUN : RAMP;
            end
            RUN: state_nx = !en ? STOP : (target != p) ? RAMP : RUN;
            STOP: begin
                p_nx     = (tick && p != '0) ? p - RES_BITS'(1) : p;
                state_nx = en ? RAMP : (p_nx == '0) ? IDLE : STOP;
            end
            default: state_nx = IDLE;
        endcase
        presc_nx = (state_nx != state || state == IDLE || state == RUN || tick) ? '0 : presc + RATE_BITS'(1);
    end
    // FSM, ramp value and prescaler registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            p      <= '0;
            presc  <= '0;
            rate_l <= RATE_BITS'(1);
        end else begin
            state  <= state_nx;
            p      <= p_nx;
            presc  <= presc_nx;
            rate_l <= (presc == '0) ? rate_cur : rate_l;
        end
    end
    // registered drive words; modulation mode may only change while idle
    always_ff @(posedge CLK) begin
        if (RST) begin
            MODULATION <= 1'b1;
            DELAY      <= '1;
            FREQUENCY  <= '1;
            AMPLITUDE  <= '0;
            STATE      <= 2'd0;
            AT_TARGET  <= 1'b0;
        end else begin
            MODULATION <= (state == IDLE) ? mod_req : MODULATION;
            DELAY      <= delay_sum[DELAY_BITS] ? '1 : delay_sum[DELAY_BITS-1:0];
            FREQUENCY  <= ~p;
            AMPLITUDE  <= (state == IDLE) ? '0 : (p > u_min_ext) ? p : u_min_ext;
            STATE      <= state;
            AT_TARGET  <= (state == RUN);
        end
    end
endmodule

// File: tb/tb_ac_motor_ramp_control.sv
// tb_ac_motor_ramp_control: directed checks of ramp timing, stop/restart, clamps and mode lock
module tb_ac_motor_ramp_control;
    logic clk, rst, enable, modulation, modulation2, at_target, at_target2;
    logic [11:0] power, frequency, amplitude, frequency2, amplitude2;
    logic [15:0] mdu, ramp_rate;
    logic [10:0] delay, delay2;
    logic [1:0] state, state2;
    logic [3:0] seen;
    int total, passed, n;

    ac_motor_ramp_control dut (
        .CLK(clk), .RST(rst), .ENABLE(enable), .POWER(power), .MOD_DELAY_UMIN(mdu),
        .RAMP_RATE(ramp_rate), .MODULATION(modulation), .DELAY(delay), .FREQUENCY(frequency),
        .AMPLITUDE(amplitude), .STATE(state), .AT_TARGET(at_target)
    );

    ac_motor_ramp_control #(.DELAY_MIN(2000)) dut2 (
        .CLK(clk), .RST(rst), .ENABLE(enable), .POWER(power), .MOD_DELAY_UMIN(mdu),
        .RAMP_RATE(ramp_rate), .MODULATION(modulation2), .DELAY(delay2), .FREQUENCY(frequency2),
        .AMPLITUDE(amplitude2), .STATE(state2), .AT_TARGET(at_target2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pack(input logic m, input logic [6:0] d, input logic [6:0] u);
        return {m, d, u, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, output int cycles);
        cycles = 0;
        seen = '0;
        do begin
            @(negedge clk);
            cycles++;
            seen[state] = 1'b1;
        end while (state != s && cycles < budget);
        chk("reach_state", 32'(state), 32'(s));
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst = 1'b1;
        enable = 1'b1;
        power = 12'd123;
        mdu = 16'h2BCD;
        ramp_rate = 16'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mod", 32'(modulation), 32'd1);
        chk("rst_delay", 32'(delay), 32'd2047);
        chk("rst_freq", 32'(frequency), 32'd4095);
        chk("rst_amp", 32'(amplitude), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_at_target", 32'(at_target), 32'd0);
        enable = 1'b0;
        power = 12'd0;
        mdu = pack(1'b1, 7'd0, 7'd0);
        ramp_rate = 16'd3;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        mdu = pack(1'b1, 7'd100, 7'd0);
        @(negedge clk);
        chk("delay_lat1", 32'(delay), 32'd1000);
        @(negedge clk);
        chk("delay_lat2", 32'(delay), 32'd1100);
        mdu = pack(1'b1, 7'd127, 7'd0);
        repeat (2) @(negedge clk);
        chk("delay_sat", 32'(delay2), 32'd2047);
        chk("delay_127", 32'(delay), 32'd1127);

        power = 12'd10;
        enable = 1'b1;
        wait_state(2'd2, 200, n);
        chk("ramp_cycles", 32'(n), 32'd33);
        chk("run_at_target", 32'(at_target), 32'd1);
        chk("run_amp", 32'(amplitude), 32'd10);
        chk("run_freq", 32'(frequency), 32'd4085);

        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("stop_state", 32'(state), 32'd3);
        repeat (5) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        chk("stop_p8", 32'(frequency), 32'd4087);
        wait_state(2'd2, 100, n);
        chk("restart_no_idle", 32'(seen[0]), 32'd0);
        chk("restart_via_ramp", 32'(seen[1]), 32'd1);
        chk("restart_freq", 32'(frequency), 32'd4085);

        mdu = pack(1'b0, 7'd127, 7'd0);
        repeat (3) @(negedge clk);
        chk("mod_locked", 32'(modulation), 32'd1);
        enable = 1'b0;
        wait_state(2'd0, 200, n);
        @(negedge clk);
        chk("mod_idle", 32'(modulation), 32'd0);
        chk("idle_amp", 32'(amplitude), 32'd0);
        chk("idle_freq", 32'(frequency), 32'd4095);

        ramp_rate = 16'd0;
        mdu = pack(1'b0, 7'd127, 7'd50);
        power = 12'd20;
        enable = 1'b1;
        wait_state(2'd2, 100, n);
        chk("rate0_cycles", 32'(n), 32'd23);
        chk("umin_amp", 32'(amplitude), 32'd50);
        chk("umin_freq", 32'(frequency), 32'd4075);

        ramp_rate = 16'd3;
        power = 12'd30;
        repeat (8) @(negedge clk);
        chk("rev_in_ramp", 32'(state), 32'd1);
        power = 12'd15;
        wait_state(2'd2, 200, n);
        chk("rev_no_stop", 32'(seen[3]), 32'd0);
        chk("rev_freq", 32'(frequency), 32'd4080);

        enable = 1'b0;
        wait_state(2'd0, 200, n);
        power = 12'd0;
        enable = 1'b1;
        wait_state(2'd2, 50, n);
        chk("zero_cycles", 32'(n), 32'd4);
        chk("zero_amp", 32'(amplitude), 32'd50);
        chk("zero_freq", 32'(frequency), 32'd4095);

        power = 12'd100;
        repeat (12) @(negedge clk);
        chk("midramp_state", 32'(state), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_state", 32'(state), 32'd0);
        chk("mrst_amp", 32'(amplitude), 32'd0);
        chk("mrst_freq", 32'(frequency), 32'd4095);
        chk("mrst_mod", 32'(modulation), 32'd1);
        chk("mrst_delay", 32'(delay), 32'd2047);
        rst = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 32'(state), 32'd0);
        chk("post_rst_freq", 32'(frequency), 32'd4095);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ac_motor_ramp_control.md
Name: ac_motor_ramp_control

Overview:
Parametrised successor to the motor setpoint stage. It converts a power setpoint and a packed modulation/delay/U_min control word into V/f drive outputs (AMPLITUDE, FREQUENCY, DELAY, MODULATION) for the modulator. Unlike the previous stage, power is slew-rate limited, start/stop is sequenced by an FSM, and the modulation mode can only change while stopped. It sits between the host register interface and the vector/sine modulator.

Parameters:
RES_BITS, 12, width of POWER, FREQUENCY, AMPLITUDE and the internal ramped power p
DELAY_BITS, 11, width of DELAY
DELAY_MIN, 1000, dead-time base added to the delay field
RATE_BITS, 16, width of RAMP_RATE and the internal prescaler

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
ENABLE  in  1  run request
POWER  in  RES_BITS  target power
MOD_DELAY_UMIN  in  16  [15] modulation (1=vector), [14:8] delay add, [7:1] U_min, [0] unused
RAMP_RATE  in  RATE_BITS  clocks per 1-LSB power step; 0 is treated as 1
MODULATION  out  1  modulation mode to modulator
DELAY  out  DELAY_BITS  dead time
FREQUENCY  out  RES_BITS  frequency word
AMPLITUDE  out  RES_BITS  amplitude word
STATE  out  2  FSM state: 0 IDLE, 1 RAMP, 2 RUN, 3 STOP
AT_TARGET  out  1  high when in RUN and p equals target

Behaviour:
- One clock, CLK. RST is synchronous and active-high.
- Reset values:
  - MODULATION=1, DELAY=all ones, FREQUENCY=all ones, AMPLITUDE=0.
  - STATE=IDLE, AT_TARGET=0, p=0, prescaler=0.
  - Input registers: target=0, u_min=0, delay_add=0, mod_req=1.
- RST asserted mid-ramp returns everything to the reset values on the next edge. There is no ramp-down on reset.
- Input stage: POWER, MOD_DELAY_UMIN and ENABLE are registered every cycle (1 cycle). The FSM and p use only the registered copies.
- Output stage: all outputs are registered from p, state and the input registers (1 cycle). Input-to-output latency with no ramp is 2 cycles.
- Prescaler and tick:
  - In RAMP and STOP, the prescaler counts 0..max(RAMP_RATE,1)-1.
  - tick=1 on the terminal count, then the prescaler wraps to 0.
  - The prescaler is cleared on every state change and in IDLE/RUN.
  - A RAMP_RATE change takes effect at the next wrap.
- FSM:
  - IDLE: p=0. mod_req is latched into MODULATION only in this state. If ENABLE=1, go to RAMP.
  - RAMP: on tick, p steps by +/-1 toward target. When p==target (checked after the step, or already equal on entry), go to RUN. If ENABLE=0, go to STOP; this has priority over reaching the target.
  - RUN: if ENABLE=0, go to STOP. Else if target!=p, go to RAMP. p is held.
  - STOP: on tick, p decrements by 1 (ignores target). When p==0, go to IDLE. If ENABLE=1 before p reaches 0, go to RAMP from the current p.
- Output arithmetic:
  - FREQUENCY = (2^RES_BITS-1) - p.
  - AMPLITUDE = 0 in IDLE; otherwise max(p, u_min), with u_min zero-extended.
  - DELAY = DELAY_MIN + delay_add, computed with one extra bit and saturated to 2^DELAY_BITS-1.
  - AT_TARGET = (state==RUN), registered.
- Boundary conditions:
  - target=0 with ENABLE=1: IDLE->RAMP->RUN with p=0. AMPLITUDE=u_min while in RUN.
  - A target change during RAMP reverses direction without a state change.
  - p never exceeds 2^RES_BITS-1 and never goes below 0.
  - A MODULATION request changed while not in IDLE is ignored until the next IDLE.

Test Plan:
1. Reset: RST high 2 cycles with arbitrary inputs -> MODULATION=1, DELAY=2047, FREQUENCY=4095, AMPLITUDE=0, STATE=0.
2. Ramp up: RAMP_RATE=3, POWER=10, U_min=0, ENABLE=1 -> p reaches 10 after 30 cycles in RAMP; then STATE=2, AT_TARGET=1, AMPLITUDE=10, FREQUENCY=4085.
3. U_min clamp: MOD_DELAY_UMIN[7:1]=50, POWER=20 ramped -> AMPLITUDE=50 until p>50 is never reached, i.e. AMPLITUDE=50 at RUN; FREQUENCY=4075.
4. Stop/restart: in RUN at p=10, drop ENABLE, raise it again after 2 ticks -> STATE 3 then 1, p=8 then climbs back to 10; no IDLE visit.
5. Delay saturation: DELAY_MIN=2000 instance, [14:8]=127 -> DELAY=2047. Default instance, [14:8]=100 -> DELAY=1100 two cycles after input.
6. Modulation lock: set [15]=0 while in RUN -> MODULATION stays 1; after stop to IDLE -> MODULATION=0. RAMP_RATE=0 -> one step per cycle.
